surf_cout_align: RTL

- Training/alignment controller directly upstream of the SURF COUT/DOUT capture PHY.
- Consumes the 4-bit-per-sysclk COUT nibble and drives the PHY's shared 6-bit IDELAY value, the COUT load strobe and the COUT bitslip strobe.
- Sweeps the linear tap range, finds the widest error-free eye, loads its centre, then bitslips until the nibble equals the training nibble.
- Reports lock, failure and eye statistics to the TURFIO register space.

---
 rtl/surf_cout_align_pkg.sv | 40 ++++
 rtl/surf_cout_err_meter.sv | 61 ++++++
 rtl/surf_cout_align.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/surf_cout_align_pkg.sv
// Shared types and helpers for the SURF COUT alignment controller.
package surf_cout_align_pkg;

    localparam int TAP_MAX = 62;
    localparam int LIN_W   = 6;
    localparam int VAL_W   = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_CENTER,
        ST_LOAD_C,
        ST_SETTLE_C,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Encoded value 32 is skipped by the PHY, so the upper half shifts by one.
    function automatic logic [VAL_W-1:0] lin2idelay(
        input logic [LIN_W-1:0] lin
    );
        return lin[5] ? lin + 6'd1 : lin;
    endfunction

    function automatic logic is_rotation(
        input logic [3:0] nib,
        input logic [3:0] pat
    );
        return (nib == pat)
            || (nib == {pat[2:0], pat[3]})
            || (nib == {pat[1:0], pat[3:2]})
            || (nib == {pat[0], pat[3:1]});
    endfunction

endpackage

// File: rtl/surf_cout_err_meter.sv
// Windowed COUT error counter: first sample is the reference for the window.
module surf_cout_err_meter
    import surf_cout_align_pkg::*;
#(
    parameter logic [3:0] PATTERN     = 4'b1000,
    parameter int         MEAS_CYCLES = 256
) (
    input  logic       sysclk_i,
    input  logic       rst_n_i,
    input  logic       start,
    input  logic [3:0] nibble,
    output logic       done,
    output logic       pass
);

    localparam int CNT_W = $clog2(MEAS_CYCLES);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ref_q;
    logic [8:0]       errs;
    logic [8:0]       errs_nx;
    logic             bad;

    always_comb begin
        bad = (cnt == '0) ? !is_rotation(nibble, PATTERN)
                          : (nibble != ref_q);
        errs_nx = errs;
        if (bad && errs != 9'h1ff)
            errs_nx = errs + 9'd1;
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active <= 1'b0;
            cnt    <= '0;
            ref_q  <= '0;
            errs   <= '0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= '0;
                errs   <= '0;
            end else if (active) begin
                if (cnt == '0)
                    ref_q <= nibble;
                errs <= errs_nx;
                cnt  <= cnt + 1'b1;
                if (cnt == CNT_W'(MEAS_CYCLES - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                    pass   <= (errs_nx == '0);
                end
            end
        end
    end

endmodule

// File: rtl/surf_cout_align.sv
// COUT IDELAY eye scan and bitslip training controller.
// Define SURF_COUT_ALIGN_EYE_MAP_EN to keep a per-tap pass map.
module surf_cout_align
    import surf_cout_align_pkg::*;
#(
    parameter logic [3:0] TRAIN_NIBBLE  = 4'b1000,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         MEAS_CYCLES   = 256,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic             sysclk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [3:0]       cout_i,
    output logic [VAL_W-1:0] idelay_value_o,
    output logic             idelay_load_o,
    output logic             bitslip_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             fail_o,
    output logic [5:0]       eye_start_o,
    output logic [6:0]       eye_width_o,
    output logic [62:0]      eye_map_o
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES) + 1;
    localparam int SLIP_W = $clog2(MAX_SLIPS + 1);

    state_t            state;
    logic [LIN_W-1:0]  lin;
    logic [SET_W-1:0]  settle_cnt;
    logic [SLIP_W-1:0] slip_cnt;
    logic [5:0]        run_start;
    logic [6:0]        run_len;
    logic [5:0]        best_start;
    logic [6:0]        best_len;
    logic              meas_done;
    logic              meas_pass;

    logic              restart;
    logic              settle_done;
    logic              meas_start;
    logic [5:0]        run_start_nx;
    logic [6:0]        cand_len;
    logic              close_run;
    logic [LIN_W-1:0]  centre;

    always_comb begin
        restart = start_i && (state == ST_IDLE
                           || state == ST_LOCKED
                           || state == ST_FAIL);
        settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
        meas_start  = (state == ST_SETTLE) && settle_done;
        run_start_nx = (meas_pass && run_len == '0) ? lin : run_start;
        cand_len  = meas_pass ? run_len + 7'd1 : run_len;
        close_run = !meas_pass || (lin == LIN_W'(TAP_MAX));
        centre = LIN_W'({1'b0, best_start}
                      + ((best_len - 7'd1) >> 1));
    end

    surf_cout_err_meter #(
        .PATTERN     (TRAIN_NIBBLE),
        .MEAS_CYCLES (MEAS_CYCLES)
    ) u_meter (
        .sysclk_i (sysclk_i),
        .rst_n_i  (rst_n_i),
        .start    (meas_start),
        .nibble   (cout_i),
        .done     (meas_done),
        .pass     (meas_pass)
    );

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_IDLE;
            lin            <= '0;
            settle_cnt     <= '0;
            slip_cnt       <= '0;
            run_start      <= '0;
            run_len        <= '0;
            best_start     <= '0;
            best_len       <= '0;
            idelay_value_o <= '0;
            idelay_load_o  <= 1'b0;
            bitslip_o      <= 1'b0;
            busy_o         <= 1'b0;
            locked_o       <= 1'b0;
            fail_o         <= 1'b0;
            eye_start_o    <= '0;
            eye_width_o    <= '0;
        end else begin
            idelay_load_o <= 1'b0;
            bitslip_o     <= 1'b0;
            if (restart) begin
                state          <= ST_LOAD;
                lin            <= '0;
                slip_cnt       <= '0;
                run_start      <= '0;
                run_len        <= '0;
                best_start     <= '0;
                best_len       <= '0;
                idelay_value_o <= lin2idelay('0);
                busy_o         <= 1'b1;
                locked_o       <= 1'b0;
                fail_o         <= 1'b0;
                eye_start_o    <= '0;
                eye_width_o    <= '0;
            end else begin
                unique case (state)
                    ST_LOAD, ST_LOAD_C: begin
                        idelay_load_o <= 1'b1;
                        settle_cnt    <= '0;
                        state <= (state == ST_LOAD) ? ST_SETTLE
                                                    : ST_SETTLE_C;
                    end
                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_done)
                            state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (meas_done)
                            state <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        run_len   <= meas_pass ? cand_len : '0;
                        run_start <= run_start_nx;
                        // Strictly longer only: ties keep the lower start.
                        if (close_run && cand_len > best_len) begin
                            best_start <= run_start_nx;
                            best_len   <= cand_len;
                        end
                        if (lin == LIN_W'(TAP_MAX)) begin
                            state <= ST_CENTER;
                        end else begin
                            lin            <= lin + 6'd1;
                            idelay_value_o <= lin2idelay(lin + 6'd1);
                            state          <= ST_LOAD;
                        end
                    end
                    ST_CENTER: begin
                        if (best_len == '0) begin
                            fail_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= ST_FAIL;
                        end else begin
                            lin            <= centre;
                            idelay_value_o <= lin2idelay(centre);
                            eye_start_o    <= best_start;
                            eye_width_o    <= best_len;
                            state          <= ST_LOAD_C;
                        end
                    end
                    ST_SETTLE_C: begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_done)
                            state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (cout_i == TRAIN_NIBBLE) begin
                            locked_o <= 1'b1;
                            busy_o   <= 1'b0;
                            state    <= ST_LOCKED;
                        end else if (slip_cnt < SLIP_W'(MAX_SLIPS)) begin
                            state <= ST_SLIP;
                        end else begin
                            fail_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= ST_FAIL;
                        end
                    end
                    ST_SLIP: begin
                        bitslip_o  <= 1'b1;
                        slip_cnt   <= slip_cnt + 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE_C;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SURF_COUT_ALIGN_EYE_MAP_EN
    logic [62:0] eye_map_q;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            eye_map_q <= '0;
        else if (restart)
            eye_map_q <= '0;
        else if (state == ST_NEXT)
            eye_map_q[lin] <= meas_pass;
    end

    assign eye_map_o = eye_map_q;
`else
    assign eye_map_o = '0;
`endif

endmodule
